seq_periph_hub: RTL and testbench

//  Parametrised instruction/result hub between the Seq sequencer and NCHAN peripheral

---
 rtl/seq_periph_hub_pkg.sv | 35 +++
 rtl/seq_hub_fifo.sv | 83 ++++++++
 rtl/seq_periph_hub.sv | 106 ++++++++++
 tb/tb_seq_periph_hub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_periph_hub_pkg.sv
// seq_periph_hub_pkg
// Shared definitions for the Seq peripheral hub.
// Holds the default widths matching the Seq oreg/ireg, the default channel
// count and FIFO depth, and the result-latch action type with a helper that
// resolves the priority between a new result and a Seq acknowledge.
// No ports: this is a package imported by seq_periph_hub and seq_hub_fifo.
package seq_periph_hub_pkg;

    localparam int SEQ_INST_WIDTH = 12;
    localparam int SEQ_RES_WIDTH  = 8;
    localparam int SEQ_DEF_NCHAN  = 4;
    localparam int SEQ_DEF_DEPTH  = 4;

    // What a channel's result latch does this cycle.
    typedef enum logic [1:0] {
        RES_HOLD  = 2'd0,
        RES_LOAD  = 2'd1,
        RES_CLEAR = 2'd2
    } res_action_e;

    // A new result always wins over an acknowledge arriving in the same
    // cycle, so Seq never loses sight of a value it has not read yet.
    // An acknowledge with nothing fresh changes nothing.
    function automatic res_action_e res_action(input logic valid,
                                               input logic ack,
                                               input logic fresh);
        if (valid) begin
            return RES_LOAD;
        end else if (ack && fresh) begin
            return RES_CLEAR;
        end
        return RES_HOLD;
    endfunction

endpackage

// File: rtl/seq_hub_fifo.sv
// seq_hub_fifo
// Synchronous show-ahead FIFO used once per hub channel.
// The head entry is presented combinationally whenever the FIFO is non-empty;
// a push into an empty FIFO becomes visible only after the clock edge, so
// there is no same-cycle bypass from push_data to head.
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   push       in   write request; ignored while full
//   push_data  in   INST_WIDTH entry to write
//   pop        in   read request; ignored while empty
//   full       out  DEPTH entries held (from registered pointers)
//   empty      out  no entries held (from registered pointers)
//   head       out  oldest entry, zero while empty
module seq_hub_fifo
    import seq_periph_hub_pkg::*;
#(
    parameter int INST_WIDTH = SEQ_INST_WIDTH,
    parameter int DEPTH      = SEQ_DEF_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [INST_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [INST_WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [INST_WIDTH-1:0] mem_d [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // The extra pointer MSB separates "full" from "empty" when the address
    // bits coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Full is judged on the registered state, so a write to a full FIFO is
    // dropped even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/seq_periph_hub.sv
// seq_periph_hub
// Instruction/result hub between the Seq sequencer and NCHAN peripheral
// channels. Each channel buffers Seq instructions in its own FIFO and hands
// them out with a valid/ready handshake; each peripheral result is latched in
// a Seq-readable ireg slice with sticky fresh and overflow flags.
// Ports:
//   clock             in   single clock, rising edge
//   reset             in   asynchronous, active-low
//   seq_oreg          in   instruction from Seq
//   seq_oreg_wen      in   per-channel write strobe, multi-hot broadcasts
//   seq_stall         out  some strobed channel is full this cycle
//   per_inst          out  FIFO head per channel, packed by channel
//   per_inst_en       out  per-channel valid (FIFO non-empty)
//   per_ready         in   peripheral accepts its head
//   per_result        in   peripheral results, packed by channel
//   per_result_valid  in   result strobe per channel
//   seq_ireg          out  last latched result per channel
//   seq_ireg_ack      in   Seq consumed a result, clears fresh
//   seq_fresh         out  sticky unread-result flag
//   seq_overflow      out  sticky dropped-write flag
module seq_periph_hub
    import seq_periph_hub_pkg::*;
#(
    parameter int NCHAN      = SEQ_DEF_NCHAN,
    parameter int INST_WIDTH = SEQ_INST_WIDTH,
    parameter int RES_WIDTH  = SEQ_RES_WIDTH,
    parameter int DEPTH      = SEQ_DEF_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [INST_WIDTH-1:0]       seq_oreg,
    input  logic [NCHAN-1:0]            seq_oreg_wen,
    output logic                        seq_stall,
    output logic [NCHAN*INST_WIDTH-1:0] per_inst,
    output logic [NCHAN-1:0]            per_inst_en,
    input  logic [NCHAN-1:0]            per_ready,
    input  logic [NCHAN*RES_WIDTH-1:0]  per_result,
    input  logic [NCHAN-1:0]            per_result_valid,
    output logic [NCHAN*RES_WIDTH-1:0]  seq_ireg,
    input  logic [NCHAN-1:0]            seq_ireg_ack,
    output logic [NCHAN-1:0]            seq_fresh,
    output logic [NCHAN-1:0]            seq_overflow
);

    logic [NCHAN-1:0]           fifo_full;
    logic [NCHAN-1:0]           fifo_empty;
    logic [NCHAN*RES_WIDTH-1:0] ireg_q, ireg_d;
    logic [NCHAN-1:0]           fresh_q, fresh_d;
    logic [NCHAN-1:0]           overflow_q, overflow_d;

    // Each channel decides on its own, so a broadcast can land in some
    // channels and be dropped by others.
    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        seq_hub_fifo #(
            .INST_WIDTH (INST_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (seq_oreg_wen[i]),
            .push_data (seq_oreg),
            .pop       (per_ready[i] & ~fifo_empty[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .head      (per_inst[i*INST_WIDTH +: INST_WIDTH])
        );
        assign per_inst_en[i] = ~fifo_empty[i];
    end

    assign seq_stall    = |(seq_oreg_wen & fifo_full);
    assign seq_ireg     = ireg_q;
    assign seq_fresh    = fresh_q;
    assign seq_overflow = overflow_q;

    always_comb begin
        ireg_d     = ireg_q;
        fresh_d    = fresh_q;
        overflow_d = overflow_q | (seq_oreg_wen & fifo_full);
        for (int i = 0; i < NCHAN; i++) begin
            case (res_action(per_result_valid[i], seq_ireg_ack[i], fresh_q[i]))
                RES_LOAD: begin
                    ireg_d[i*RES_WIDTH +: RES_WIDTH] = per_result[i*RES_WIDTH +: RES_WIDTH];
                    fresh_d[i]                       = 1'b1;
                end
                RES_CLEAR: begin
                    fresh_d[i] = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ireg_q     <= '0;
            fresh_q    <= '0;
            overflow_q <= '0;
        end else begin
            ireg_q     <= ireg_d;
            fresh_q    <= fresh_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_seq_periph_hub.sv
// tb_seq_periph_hub
// Directed bench for seq_periph_hub with its default parameters
// (NCHAN=4, INST_WIDTH=12, RES_WIDTH=8, DEPTH=4). Inputs change on the
// falling edge; outputs are sampled between rising edges.
module tb_seq_periph_hub;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] seqOreg;
    logic [3:0]  seqOregWen;
    logic        seqStall;
    logic [47:0] perInst;
    logic [3:0]  perInstEn;
    logic [3:0]  perReady;
    logic [31:0] perResult;
    logic [3:0]  perResultValid;
    logic [31:0] seqIreg;
    logic [3:0]  seqIregAck;
    logic [3:0]  seqFresh;
    logic [3:0]  seqOverflow;

    int totalChecks = 0;
    int badChecks   = 0;

    seq_periph_hub dut (
        .clock            (clock),
        .reset            (reset),
        .seq_oreg         (seqOreg),
        .seq_oreg_wen     (seqOregWen),
        .seq_stall        (seqStall),
        .per_inst         (perInst),
        .per_inst_en      (perInstEn),
        .per_ready        (perReady),
        .per_result       (perResult),
        .per_result_valid (perResultValid),
        .seq_ireg         (seqIreg),
        .seq_ireg_ack     (seqIregAck),
        .seq_fresh        (seqFresh),
        .seq_overflow     (seqOverflow)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle's worth of inputs and lets combinational paths settle.
    task automatic applyStimulus(input logic [3:0] wen, input logic [11:0] inst,
                                 input logic [3:0] ready, input logic [3:0] rvalid,
                                 input logic [3:0] ack);
        seqOregWen     = wen;
        seqOreg        = inst;
        perReady       = ready;
        perResultValid = rvalid;
        seqIregAck     = ack;
        #1;
    endtask

    function automatic logic [11:0] instOf(input int ch);
        return perInst[ch*12 +: 12];
    endfunction

    function automatic logic [7:0] iregOf(input int ch);
        return seqIreg[ch*8 +: 8];
    endfunction

    initial begin
        reset     = 1'b0;
        perResult = '0;
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b0000, 4'b0000);

        // Reset state
        @(negedge clock);
        checkOutput("rst_en",       32'(perInstEn),   32'h0);
        checkOutput("rst_inst",     32'(perInst),     32'h0);
        checkOutput("rst_ireg",     seqIreg,          32'h0);
        checkOutput("rst_fresh",    32'(seqFresh),    32'h0);
        checkOutput("rst_overflow", 32'(seqOverflow), 32'h0);
        checkOutput("rst_stall",    32'(seqStall),    32'h0);
        reset = 1'b1;
        @(negedge clock);

        // Reset mid-stream: two entries in ch0 plus a fresh result on ch1
        perResult[8 +: 8] = 8'h33;
        applyStimulus(4'b0001, 12'h011, 4'b0000, 4'b0010, 4'b0000);
        @(negedge clock);
        applyStimulus(4'b0001, 12'h012, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clock);
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("mid_en",    32'(perInstEn), 32'h1);
        checkOutput("mid_head0", 32'(instOf(0)), 32'h011);
        checkOutput("mid_fresh", 32'(seqFresh),  32'h2);
        checkOutput("mid_ireg1", 32'(iregOf(1)), 32'h33);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_en",       32'(perInstEn),   32'h0);
        checkOutput("async_inst",     32'(perInst),     32'h0);
        checkOutput("async_ireg",     seqIreg,          32'h0);
        checkOutput("async_fresh",    32'(seqFresh),    32'h0);
        checkOutput("async_overflow", 32'(seqOverflow), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_en", 32'(perInstEn), 32'h0);

        // Ordering on ch1
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, 12'h101 + 12'(k), 4'b0000, 4'b0000, 4'b0000);
            @(negedge clock);
        end
        applyStimulus(4'b0000, 12'h000, 4'b0010, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            checkOutput("order_en",   32'(perInstEn[1]), 32'h1);
            checkOutput("order_head", 32'(instOf(1)),    32'h101 + 32'(k));
            @(negedge clock);
        end
        checkOutput("order_empty", 32'(perInstEn), 32'h0);

        // Fill ch2, then a fifth write must stall and drop
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0100, 12'h201 + 12'(k), 4'b0000, 4'b0000, 4'b0000);
            checkOutput("fill_stall", 32'(seqStall), 32'h0);
            @(negedge clock);
        end
        applyStimulus(4'b0100, 12'h205, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("full_stall", 32'(seqStall), 32'h1);
        @(negedge clock);
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("full_overflow", 32'(seqOverflow), 32'h4);
        checkOutput("full_en",       32'(perInstEn),   32'h4);
        checkOutput("full_head",     32'(instOf(2)),   32'h201);
        checkOutput("idle_stall",    32'(seqStall),    32'h0);
        @(negedge clock);
        checkOutput("hold_head", 32'(instOf(2)), 32'h201);

        // Full plus pop in the same cycle: pop happens, write is dropped
        applyStimulus(4'b0100, 12'h2FF, 4'b0100, 4'b0000, 4'b0000);
        checkOutput("fullpop_stall", 32'(seqStall), 32'h1);
        @(negedge clock);
        applyStimulus(4'b0000, 12'h000, 4'b0100, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            checkOutput("drain_head", 32'(instOf(2)), 32'h202 + 32'(k));
            @(negedge clock);
        end
        checkOutput("drain_empty",    32'(perInstEn),   32'h0);
        checkOutput("drain_overflow", 32'(seqOverflow), 32'h4);

        // Broadcast with ch2 full, starting from cleared flags
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checkOutput("bc_rst_overflow", 32'(seqOverflow), 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0100, 12'h211 + 12'(k), 4'b0000, 4'b0000, 4'b0000);
            @(negedge clock);
        end
        applyStimulus(4'b0101, 12'h0AA, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("bc_stall", 32'(seqStall), 32'h1);
        @(negedge clock);
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("bc_en",       32'(perInstEn),   32'h5);
        checkOutput("bc_head0",    32'(instOf(0)),   32'h0AA);
        checkOutput("bc_head2",    32'(instOf(2)),   32'h211);
        checkOutput("bc_head1",    32'(instOf(1)),   32'h0);
        checkOutput("bc_head3",    32'(instOf(3)),   32'h0);
        checkOutput("bc_overflow", 32'(seqOverflow), 32'h4);

        // Results on ch3
        perResult[24 +: 8] = 8'h5C;
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b1000, 4'b0000);
        @(negedge clock);
        checkOutput("res_ireg",  32'(iregOf(3)), 32'h5C);
        checkOutput("res_fresh", 32'(seqFresh),  32'h8);
        perResult[24 +: 8] = 8'h7E;
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b1000, 4'b1000);
        @(negedge clock);
        checkOutput("res_va_ireg",  32'(iregOf(3)), 32'h7E);
        checkOutput("res_va_fresh", 32'(seqFresh),  32'h8);
        perResult[24 +: 8] = 8'h11;
        applyStimulus(4'b0000, 12'h000, 4'b0000, 4'b0000, 4'b1000);
        @(negedge clock);
        checkOutput("res_ack_fresh", 32'(seqFresh),  32'h0);
        checkOutput("res_ack_ireg",  32'(iregOf(3)), 32'h7E);
        @(negedge clock);
        checkOutput("res_noop_fresh", 32'(seqFresh),  32'h0);
        checkOutput("res_noop_ireg",  32'(iregOf(3)), 32'h7E);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
